serial_adder: RTL
=================

# serial_adder

Bit-serial multi-bit adder built around the existing structural `full_adder` cell and a registered carry. It accepts two `WIDTH`-bit operands and a carry-in on a start strobe, then adds one bit per clock, LSB first. It presents the registered `WIDTH`-bit sum and carry-out with a one-cycle `done` pulse. It is the sequential stage directly downstream of the full adder: it consumes the cell's `sum`/`carry` outputs every cycle, trading latency for a single adder cell.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range ≥ 2.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request strobe; sampled only in IDLE.
- `a` input WIDTH: operand A; captured on accepted `start`.
- `b` input WIDTH: operand B; captured on accepted `start`.
- `cin` input 1: carry-in; captured on accepted `start`.
- `busy` output 1: high whenever state ≠ IDLE.
- `done` output 1: one-cycle pulse; result valid.
- `sum` output WIDTH: registered result; holds until the next `done`.
- `cout` output 1: registered carry-out; holds with `sum`.

## Operation
- Internal registers:
  - `a_sr`, `b_sr`: operand shift registers, shift right.
  - `s_sr`: sum shift register, fills from the MSB.
  - `carry_q`: running carry.
  - `cnt`: bit counter, width `$clog2(WIDTH)`.
- Full-adder cell inputs each cycle: `a_sr[0]`, `b_sr[0]`, `carry_q`. Outputs are `fa_sum` and `fa_carry`.
- FSM has states IDLE, SHIFT, DONE.
- IDLE:
  - If `start` = 1: load `a_sr` ← `a`, `b_sr` ← `b`, `carry_q` ← `cin`, `cnt` ← 0; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, on every edge:
  - `s_sr` ← {`fa_sum`, `s_sr[WIDTH-1:1]`}
  - `a_sr` ← `a_sr` >> 1, `b_sr` ← `b_sr` >> 1
  - `carry_q` ← `fa_carry`
  - `cnt` ← `cnt` + 1
  - When `cnt` = WIDTH-1 on that edge, go to DONE instead of staying in SHIFT.
- DONE:
  - Output registers are written on the SHIFT→DONE edge: `sum` ← final `s_sr` (including the last `fa_sum`), `cout` ← final `fa_carry`.
  - `done` = 1 for exactly this one cycle; next state is unconditionally IDLE.
- `start` in SHIFT or DONE is ignored and not queued.
- Arithmetic: {`cout`, `sum`} = `a` + `b` + `cin`, exact, modulo 2^(WIDTH+1). No overflow flag.
- Input stability: `a`, `b`, `cin` may change freely after the accepting edge; only captured copies are used.
- Reset:
  - `rst` = 1 at any edge forces state IDLE, `busy` = 0, `done` = 0, `sum` = 0, `cout` = 0, `cnt` = 0, `carry_q` = 0.
  - Reset has priority over `start`.
  - Reset mid-SHIFT aborts the operation; no `done` is produced.

## Timing
- `start` is accepted at edge k.
- SHIFT occupies edges k+1 … k+WIDTH.
- `done` = 1, with `sum`/`cout` valid, during the cycle after edge k+WIDTH. Latency is WIDTH+1 cycles from the accepting edge.
- `busy` rises after edge k and falls after edge k+WIDTH+1.
- Throughput with `start` held high: one operation per WIDTH+2 cycles, because IDLE is re-entered for one cycle before the next accept.
- `done`, `busy`, `sum`, `cout` are all registered outputs; no combinational input-to-output path.

## Structure
- Shared package/header `adder_pkg`:
  - State encoding localparams: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2.
  - Default `WIDTH`.
- Sub-module: one instance of the existing `full_adder`, named `u_fa`. No other sub-modules.
- The FSM, counter and shift registers live in `serial_adder`.

## Test plan
- WIDTH=8, `a`=0x5A, `b`=0x3C, `cin`=0, `start` pulse -> `done` 9 cycles after the accepting edge, `sum`=0x96, `cout`=0.
- `a`=0xFF, `b`=0x01, `cin`=0 -> `sum`=0x00, `cout`=1. Then `a`=0xFF, `b`=0xFF, `cin`=1 -> `sum`=0xFF, `cout`=1.
- Start 0x10+0x20; pulse `start` with 0x01+0x01 at SHIFT cycle 3 -> ignored; exactly one `done` with `sum`=0x30, `cout`=0.
- Assert `rst` at SHIFT cycle 4 of 0xAA+0x55 -> next cycle `busy`=0, `done`=0, `sum`=0x00, `cout`=0; no `done` follows.
- `start` held high for 30 cycles with constant `a`=0x01, `b`=0x02 -> `done` pulses every 10 cycles, each with `sum`=0x03.
- Random sweep, 1000 operands including `cin`, checked against a reference model -> {`cout`, `sum`} = `a`+`b`+`cin`; `done` width always 1 cycle.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/full_adder.sv
// Structural one-bit full adder cell; the only arithmetic in the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell plus a registered carry, LSB first,
// with a one-cycle done pulse and registered sum/cout that hold until the next result.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_carry;
  logic             last_bit;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .carry(fa_carry)
  );

  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: begin busy = 1'b0; done = 1'b0; end
    endcase
  end

  // Control-side registers: carry, bit counter and the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            carry_q <= cin;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          carry_q <= fa_carry;
          cnt     <= cnt + 1'b1;
          if (last_bit) begin
            sum  <= {fa_sum, s_sr[WIDTH-1:1]};
            cout <= fa_carry;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand and partial-sum shift registers carry no reset; they are reloaded on every accept.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_sr <= a;
      b_sr <= b;
    end else if (state == SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      s_sr <= {fa_sum, s_sr[WIDTH-1:1]};
    end
  end

endmodule
